// File: rtl/puck_pkg.sv
// Shared types and helpers for the puck motion controller.
package puck_pkg;

    typedef enum logic [2:0] {StHold, StWait, StHit, StMove, StEdge} state_e;

    localparam int unsigned VelW = 5;

    // Clamp a 13-bit signed value to [-lim, +lim] and narrow it to a velocity.
    function automatic logic signed [VelW-1:0] sat(input logic signed [12:0] val,
                                                   input logic signed [12:0] lim);
        logic signed [12:0] r;
        if (val > lim) begin
            r = lim;
        end else if (val < -lim) begin
            r = -lim;
        end else begin
            r = val;
        end
        return r[VelW-1:0];
    endfunction

endpackage

// File: rtl/circle_hit.sv
// Circle contact test: flags when dx^2 + dy^2 is within a squared limit.
module circle_hit
    import puck_pkg::*;
(
    input  logic [12:0] dx_i,
    input  logic [12:0] dy_i,
    input  logic [25:0] limit_i,
    output logic        hit_o
);

    logic signed [25:0] dx_s;
    logic signed [25:0] dy_s;
    logic        [25:0] dx_sq;
    logic        [25:0] dy_sq;

    assign dx_s = {{13{dx_i[12]}}, dx_i};
    assign dy_s = {{13{dy_i[12]}}, dy_i};

    // |d| <= 4096 so each square fits in 25 bits and the sum in 26.
    assign dx_sq = $unsigned(dx_s * dx_s);
    assign dy_sq = $unsigned(dy_s * dy_s);

    assign hit_o = (dx_sq + dy_sq) <= limit_i;

endmodule

// File: rtl/puck_ctl.sv
// Per-frame puck motion: serve timing, mallet hits, wall reflection and goals.
module puck_ctl
    import puck_pkg::*;
#(
    parameter int unsigned H_RES        = 1024,
    parameter int unsigned V_RES        = 768,
    parameter int unsigned RADIUS       = 20,
    parameter int unsigned MALLET_R     = 30,
    parameter int unsigned GOAL_TOP     = 284,
    parameter int unsigned GOAL_BOT     = 484,
    parameter int unsigned MAX_SPEED    = 8,
    parameter int unsigned SERVE_SPEED  = 2,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [11:0] mallet1_x,
    input  logic [11:0] mallet1_y,
    input  logic [11:0] mallet2_x,
    input  logic [11:0] mallet2_y,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        goal_left,
    output logic        goal_right
);

    localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);

    localparam logic [11:0]        XCen    = 12'(H_RES / 2);
    localparam logic [11:0]        YCen    = 12'(V_RES / 2);
    localparam logic signed [12:0] RadS    = 13'(RADIUS);
    localparam logic signed [12:0] XMax    = 13'(H_RES - 1 - RADIUS);
    localparam logic signed [12:0] YMax    = 13'(V_RES - 1 - RADIUS);
    localparam logic signed [12:0] GoalTop = 13'(GOAL_TOP);
    localparam logic signed [12:0] GoalBot = 13'(GOAL_BOT);
    localparam logic signed [12:0] MaxS    = 13'(MAX_SPEED);
    localparam logic [25:0]        HitLim  = 26'((RADIUS + MALLET_R) * (RADIUS + MALLET_R));
    localparam logic signed [VelW-1:0] ServeV  = VelW'(SERVE_SPEED);
    localparam logic signed [VelW-1:0] VelOne  = VelW'(1);
    localparam logic signed [VelW-1:0] VelZero = '0;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   serve_pos_q, serve_pos_d;
    logic signed [VelW-1:0] vx_q, vx_d;
    logic signed [VelW-1:0] vy_q, vy_d;
    logic [11:0]            x_q, x_d;
    logic [11:0]            y_q, y_d;
    logic signed [12:0]     nx_q, nx_d;
    logic signed [12:0]     ny_q, ny_d;
    logic                   goal_l_q, goal_l_d;
    logic                   goal_r_q, goal_r_d;
    logic                   vblnk_q;

    logic                   tick;
    logic [CntW-1:0]        cnt_inc;
    logic signed [12:0]     dx1, dy1, dx2, dy2;
    logic                   hit1, hit2;
    logic signed [VelW-1:0] hvx, hvy;
    logic signed [12:0]     y_n, x_n;
    logic                   in_band;

    assign tick    = vblnk_in & ~vblnk_q;
    assign cnt_inc = cnt_q + 1'b1;

    assign dx1 = $signed({1'b0, x_q}) - $signed({1'b0, mallet1_x});
    assign dy1 = $signed({1'b0, y_q}) - $signed({1'b0, mallet1_y});
    assign dx2 = $signed({1'b0, x_q}) - $signed({1'b0, mallet2_x});
    assign dy2 = $signed({1'b0, y_q}) - $signed({1'b0, mallet2_y});

    circle_hit u_hit1 (
        .dx_i    (dx1),
        .dy_i    (dy1),
        .limit_i (HitLim),
        .hit_o   (hit1)
    );

    circle_hit u_hit2 (
        .dx_i    (dx2),
        .dy_i    (dy2),
        .limit_i (HitLim),
        .hit_o   (hit2)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        serve_pos_d = serve_pos_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        x_d         = x_q;
        y_d         = y_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        goal_l_d    = 1'b0;
        goal_r_d    = 1'b0;
        hvx         = VelZero;
        hvy         = VelZero;
        y_n         = ny_q;
        x_n         = nx_q;
        in_band     = 1'b0;

        unique case (state_q)
            StHold: begin
                if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(SERVE_FRAMES)) begin
                        vx_d    = serve_pos_q ? ServeV : -ServeV;
                        vy_d    = VelZero;
                        cnt_d   = '0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (tick) begin
                    state_d = StHit;
                end
            end
            StHit: begin
                if (hit1) begin
                    hvx = sat(dx1 >>> 2, MaxS);
                    hvy = sat(dy1 >>> 2, MaxS);
                    vx_d = (hvx == VelZero && hvy == VelZero) ? VelOne : hvx;
                    vy_d = hvy;
                end else if (hit2) begin
                    hvx = sat(dx2 >>> 2, MaxS);
                    hvy = sat(dy2 >>> 2, MaxS);
                    vx_d = (hvx == VelZero && hvy == VelZero) ? -VelOne : hvx;
                    vy_d = hvy;
                end
                state_d = StMove;
            end
            StMove: begin
                nx_d    = $signed({1'b0, x_q}) + {{(13 - VelW){vx_q[VelW-1]}}, vx_q};
                ny_d    = $signed({1'b0, y_q}) + {{(13 - VelW){vy_q[VelW-1]}}, vy_q};
                state_d = StEdge;
            end
            StEdge: begin
                if (ny_q < RadS) begin
                    y_n  = RadS;
                    vy_d = -vy_q;
                end else if (ny_q > YMax) begin
                    y_n  = YMax;
                    vy_d = -vy_q;
                end
                // Goal band is tested on the already-clamped y.
                in_band = (y_n >= GoalTop) && (y_n <= GoalBot);
                if (nx_q < RadS && in_band) begin
                    goal_l_d    = 1'b1;
                    serve_pos_d = 1'b0;
                end else if (nx_q > XMax && in_band) begin
                    goal_r_d    = 1'b1;
                    serve_pos_d = 1'b1;
                end else if (nx_q < RadS) begin
                    x_n  = RadS;
                    vx_d = -vx_q;
                end else if (nx_q > XMax) begin
                    x_n  = XMax;
                    vx_d = -vx_q;
                end

                if (goal_l_d || goal_r_d) begin
                    x_d     = XCen;
                    y_d     = YCen;
                    vx_d    = VelZero;
                    vy_d    = VelZero;
                    state_d = StHold;
                end else begin
                    x_d     = x_n[11:0];
                    y_d     = y_n[11:0];
                    state_d = StWait;
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            serve_pos_q <= 1'b1;
            vx_q        <= VelZero;
            vy_q        <= VelZero;
            x_q         <= XCen;
            y_q         <= YCen;
            nx_q        <= '0;
            ny_q        <= '0;
            goal_l_q    <= 1'b0;
            goal_r_q    <= 1'b0;
            // Held high so a vblank already in progress at release is not a tick.
            vblnk_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            serve_pos_q <= serve_pos_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            goal_l_q    <= goal_l_d;
            goal_r_q    <= goal_r_d;
            vblnk_q     <= vblnk_in;
        end
    end

    assign xpos_out   = x_q;
    assign ypos_out   = y_q;
    assign goal_left  = goal_l_q;
    assign goal_right = goal_r_q;

endmodule
